tt_um_gate_arbiter: RTL and testbench

TT_UM_GATE_ARBITER -- requirements
Module: tt_um_gate_arbiter

---
 rtl/tt_um_gate_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_tt_um_gate_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_gate_arbiter.sv
// Four-requester round-robin arbiter sharing one 2-input gate unit (IDLE -> EXEC -> RESP).
// Define GATE_ARB_OPSEL_EN to latch a per-grant op select (AND/OR/XOR/NAND); otherwise the gate is AND.
module tt_um_gate_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] TIMEOUT_C = TIMEOUT[3:0];

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] gidx_q, gidx_d;
    logic [1:0] ptr_q, ptr_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [1:0] op_q, op_d;
    logic       result_q, result_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] cand_s;
    logic [1:0] pick_idx_s;
    logic       pick_found_s;
    logic       req_held_s;
    logic [3:0] cnt_inc_s;
    logic [1:0] op_sel_s;
    logic       unused_s;

    function automatic logic gate_eval(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            2'b11:   r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef GATE_ARB_OPSEL_EN
    assign op_sel_s = ui_in[5:4];
`else
    assign op_sel_s = 2'b00;
`endif

    assign req_held_s = |(ui_in[3:0] & grant_q);
    assign cnt_inc_s  = cnt_q + 4'd1;
    assign unused_s   = ^{ena, ui_in[7:4]};

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = ptr_q;
        cand_s       = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!pick_found_s && ui_in[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = EXEC;
                    grant_d = 4'b0001 << pick_idx_s;
                    gidx_d  = pick_idx_s;
                    a_d     = uio_in[{pick_idx_s, 1'b0}];
                    b_d     = uio_in[{pick_idx_s, 1'b1}];
                    op_d    = op_sel_s;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            EXEC: begin
                if (!req_held_s) begin
                    // Requester withdrew before its result was produced: abort silently.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = gidx_q;
                end else begin
                    state_d  = RESP;
                    result_d = gate_eval(op_q, a_q, b_q);
                    valid_d  = 1'b1;
                    cnt_d    = 4'd0;
                end
            end
            RESP: begin
                if (!req_held_s || (cnt_inc_s == TIMEOUT_C)) begin
                    state_d  = IDLE;
                    grant_d  = 4'b0000;
                    result_d = 1'b0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b0;
                    cnt_d    = 4'd0;
                    ptr_d    = gidx_q;
                    if (req_held_s) begin
                        timeout_d = 1'b1;
                    end else begin
                        timeout_d = timeout_q;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = 4'b0000;
                result_d = 1'b0;
                valid_d  = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = 4'd0;
            end
        endcase
    end

    // State and output registers; reset lets requester 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            gidx_q    <= 2'd0;
            ptr_q     <= 2'd3;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            op_q      <= 2'b00;
            result_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign uo_out  = {timeout_q, busy_q, valid_q, result_q, grant_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_gate_arbiter.sv
// Bench for tt_um_gate_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tt_um_gate_arbiter;

    localparam int TO = 15;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tt_um_gate_arbiter #(.TIMEOUT(TO)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int         m_owner = -1;  // index of current owner, -1 when nobody holds the gate
    int         m_age   = 0;   // 0 = operation in flight, 1..TO = cycles with result presented
    int         m_ptr   = 3;
    logic       m_a = 1'b0, m_b = 1'b0, m_tmo = 1'b0;
    logic [1:0] m_op = 2'b00;

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 1; k <= 4; k++)
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic gate_ref(input logic [1:0] op, input logic a, input logic b);
`ifdef GATE_ARB_OPSEL_EN
        if (op == 2'b00) return a && b;
        if (op == 2'b01) return a || b;
        if (op == 2'b10) return a != b;
        return !(a && b);
`else
        return a && b;
`endif
    endfunction

    function automatic logic [7:0] model_uo();
        logic [7:0] u;
        logic       v;
        v = (m_owner >= 0) && (m_age >= 1);
        u = 8'h00;
        if (m_owner >= 0) u[m_owner] = 1'b1;
        u[4] = v ? gate_ref(m_op, m_a, m_b) : 1'b0;
        u[5] = v;
        u[6] = (m_owner >= 0);
        u[7] = m_tmo;
        return u;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1; m_age <= 0; m_ptr <= 3; m_tmo <= 1'b0;
        end else if (m_owner < 0) begin
            if (ui_in[3:0] != 4'h0) begin
                m_owner <= rr_pick(ui_in[3:0], m_ptr);
                m_age   <= 0;
                m_a     <= uio_in[2 * rr_pick(ui_in[3:0], m_ptr)];
                m_b     <= uio_in[2 * rr_pick(ui_in[3:0], m_ptr) + 1];
                m_op    <= ui_in[5:4];
            end
        end else if (!ui_in[m_owner]) begin
            m_ptr <= m_owner; m_owner <= -1; m_age <= 0;
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (m_age == TO) begin
            m_ptr <= m_owner; m_owner <= -1; m_age <= 0; m_tmo <= 1'b1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cycle", {8'h00, uio_oe, uio_out, uo_out}, {16'h0000, model_uo()});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic txn(input string name, input int idx, input logic [1:0] op,
                       input logic a, input logic b, input logic exp_res);
        logic [7:0] v;
        logic [3:0] r;
        v = 8'h00;
        v[2 * idx]     = a;
        v[2 * idx + 1] = b;
        r = 4'h0;
        r[idx] = 1'b1;
        ui_in  = {2'b11, op, r};
        uio_in = v;
        tick();
        uio_in = ~v;
        tick();
        check(name, {30'd0, uo_out[5:4]}, {30'd0, 1'b1, exp_res});
        ui_in = 8'h00;
        tick();
    endtask

    logic [3:0] got_grant [5];
    logic [3:0] exp_grant [5];
    int n;
    int run;

    initial begin
        exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000; exp_grant[4] = 4'b0001;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset", {24'd0, uo_out}, {24'd0, 8'h00});

        // Single request, AND of 1,1
        ui_in  = 8'h01;
        uio_in = 8'h03;
        tick();
        check("t1_grant", {24'd0, uo_out}, {24'd0, 8'h41});
        uio_in = 8'h00;
        tick();
        check("t1_valid", {24'd0, uo_out}, {24'd0, 8'h71});
        ui_in = 8'h00;
        tick();
        check("t1_idle", {24'd0, uo_out}, {24'd0, 8'h00});

`ifdef GATE_ARB_OPSEL_EN
        txn("op_xor11", 0, 2'b10, 1'b1, 1'b1, 1'b0);
        txn("op_nand11", 1, 2'b11, 1'b1, 1'b1, 1'b0);
        txn("op_or10", 2, 2'b01, 1'b1, 1'b0, 1'b1);
        txn("op_and01", 3, 2'b00, 1'b0, 1'b1, 1'b0);
`else
        txn("and_ignores_op", 0, 2'b11, 1'b1, 1'b1, 1'b1);
        txn("and10", 1, 2'b01, 1'b1, 1'b0, 1'b0);
        txn("and01_op10", 2, 2'b10, 1'b0, 1'b1, 1'b0);
`endif

        // Round robin with all four requesting; ptr realigned to 3 by a reset first
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        uio_in = 8'hA5;
        ui_in  = 8'h0F;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (!uo_out[5] && n < 10) begin tick(); n++; end
            check("t2_valid_seen", n < 10, 1);
            got_grant[g] = uo_out[3:0];
            ui_in = {4'h0, 4'hF & ~uo_out[3:0]};
            tick();
            ui_in = (g < 4) ? 8'h0F : 8'h00;
        end
        tick();
        for (int g = 0; g < 5; g++)
            check($sformatf("t2_grant%0d", g), {28'd0, got_grant[g]}, {28'd0, exp_grant[g]});

        // Timeout: requester 2 holds its request
        ui_in = 8'h04;
        n = 0;
        while (!uo_out[5] && n < 10) begin tick(); n++; end
        check("t3_valid_seen", n < 10, 1);
        run = 0;
        while (uo_out[5] && run < 40) begin run++; tick(); end
        check("t3_resp_cycles", run, TO);
        check("t3_exit", {24'd0, uo_out}, {24'd0, 8'h80});
        ui_in = 8'h00;
        tick();
        tick();
        check("t3_sticky_hold", {24'd0, uo_out}, {24'd0, 8'h80});

        // Abort in EXEC, pointer moves to the aborted requester
        ui_in = 8'h02;
        tick();
        check("t4_grant", {24'd0, uo_out}, {24'd0, 8'hC2});
        ui_in = 8'h00;
        tick();
        check("t4_abort", {24'd0, uo_out}, {24'd0, 8'h80});
        ui_in = 8'h0F;
        tick();
        check("t4_ptr", {28'd0, uo_out[3:0]}, {28'd0, 4'b0100});
        ui_in = 8'h00;
        tick();
        tick();

        // Asynchronous reset in the middle of RESP
        ui_in  = 8'h01;
        uio_in = 8'h03;
        tick();
        tick();
        check("t5_valid", {24'd0, uo_out}, {24'd0, 8'hF1});
        #2 rst_n = 1'b0;
        #1 check("t5_async", {24'd0, uo_out}, {24'd0, 8'h00});
        ui_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t5_no_valid", {24'd0, uo_out}, {24'd0, 8'h00});
        ui_in = 8'h0F;
        tick();
        check("t5_rr0", {28'd0, uo_out[3:0]}, {28'd0, 4'b0001});
        ui_in = 8'h00;
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
